uart_word_receiver: RTL and testbench
=====================================

// Module: uart_word_receiver
// PURPOSE
//  Serial receiver paired with the 32-bit UART word transmitter; consumes its tx line.
//  Frame format: start(0), BITS_PER_WORD data bits LSB first, parity, stop(1).
//  Each bit lasts CLOCK_DIVIDER clk cycles.
//  Recovers the word, checks parity and stop bit, and presents the result with a one-cycle valid strobe.
// PARAMETERS
//  BITS_PER_WORD  32  data bits per frame
//  CLOCK_DIVIDER  16  clk cycles per bit; must be even and >= 4; SP = CLOCK_DIVIDER/2 is the sample point
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous, active-high reset
//  rx           in   1   asynchronous serial line; idle high
//  parity_type  in   1   1: parity = ^data; 0: parity = ~^data (same rule as the transmitter)
//  data         out  32  last received word; held until the next valid
//  valid        out  1   one-cycle strobe; data, parity_err and frame_err are updated in the same cycle
//  parity_err   out  1   received parity != expected; held until the next valid
//  frame_err    out  1   stop bit sampled low; held until the next valid
//  busy         out  1   high from start-edge detection until the frame completes or is aborted
// BEHAVIOUR
//  Reset values: data=0, valid=0, parity_err=0, frame_err=0, busy=0, state=IDLE.
//  Synchronizer flops reset to 1; armed resets to 0.
//  rx passes through a 2-flop synchronizer (rx_s); all decisions use rx_s only.
//  bit_cnt counts 0..CLOCK_DIVIDER-1 and is zeroed on start detection and at each bit boundary.
//  States:
//   IDLE:   armed<=1 once rx_s==1. If armed && rx_s==0: bit_cnt<=0, busy<=1, go START.
//   START:  at bit_cnt==SP, rx_s==1 -> false start: busy<=0, go IDLE, no valid.
//           At bit_cnt==CLOCK_DIVIDER-1 -> go DATA with bit_pos=0.
//   DATA:   sample at SP into shift[bit_pos]. At bit_cnt==CLOCK_DIVIDER-1:
//           bit_pos==BITS_PER_WORD-1 -> go PARITY; otherwise bit_pos+1.
//   PARITY: sample at SP into par_rx. At bit_cnt==CLOCK_DIVIDER-1 -> go STOP.
//   STOP:   at the sample decision: data<=shift; valid<=1 for the next cycle only;
//           parity_err<=(par_rx != (parity_type ? ^shift : ~^shift));
//           frame_err<=~stop_sample; busy<=0; go IDLE.
//           IDLE is entered half a bit early so back-to-back frames are accepted.
//  Re-arm after a frame error: armed<=0, so a line held low (break) yields no new frame until rx_s returns high.
//  parity_type is sampled when STOP decides; it must remain stable during a frame.
//  Latency: valid is asserted (2 + 34*CLOCK_DIVIDER + SP + 1) cycles after the rx falling edge, +1 with the majority-vote macro.
//  A word with an error is still delivered with valid=1; the consumer decides whether to drop it.
//  No backpressure: a new valid overwrites data whether or not the previous word was read.
//  rst mid-frame: next cycle is in IDLE with all outputs at reset values and no valid.
//  A frame already in progress on the line is then ignored until rx_s is seen high.
// CONFIGURATION
//  UART_RX_MAJORITY_VOTE_EN defined:
//   - each bit (start, data, parity, stop) is the 2-of-3 majority of rx_s at SP-1, SP, SP+1;
//   - the decision is taken at SP+1;
//   - single-cycle line glitches are rejected.
//  Not defined: single sample at SP, decision at SP. No other behaviour differs.
// STRUCTURE
//  uart_pkg: state encoding (IDLE, START, DATA, PARITY, STOP);
//            default BITS_PER_WORD and CLOCK_DIVIDER;
//            parity helper function shared with the transmitter.
//  Sub-module uart_rx_sync: 2-flop synchronizer with a reset value parameter (1 here).
//  Everything else is in one FSM/datapath always block.
// TESTING
//  1. Loopback through the transmitter, data=32'hA5A5_0F0F, parity_type=1:
//     exactly one valid, data=32'hA5A5_0F0F, parity_err=0, frame_err=0, busy low after.
//  2. Directly driven frame for 32'h1234_5678 with the parity bit inverted:
//     valid=1, data=32'h1234_5678, parity_err=1, frame_err=0.
//  3. Frame for 32'hFFFF_FFFF with the stop bit low, then rx held low 100 bit times:
//     one valid with frame_err=1, then no busy/valid until rx returns high.
//     A following frame is received correctly.
//  4. rx low for CLOCK_DIVIDER/4 cycles only: busy pulses, then returns to 0; no valid.
//  5. Back-to-back loopback of 32'h0000_0001 then 32'h8000_0000 with no idle gap:
//     two valids, correct data, no errors.
//  6. rst asserted at data bit 10 of a frame: outputs at reset values the next cycle.
//     Remainder of that frame ignored; the next full frame is received correctly.
//     With UART_RX_MAJORITY_VOTE_EN: a 1-cycle glitch at SP of bit 3 is rejected (no error).
//     Without the macro: the same glitch flips bit 3 and sets parity_err=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART word receiver (and its paired transmitter):
// receiver state encoding, default frame geometry and the parity rule.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam int DEFAULT_BITS_PER_WORD = 32;
  localparam int DEFAULT_CLOCK_DIVIDER = 16;

  // Parity bit for a word whose XOR-reduction is xor_all.
  // parity_type=1 -> odd-count-of-ones rule (^data), 0 -> its inverse (~^data).
  function automatic logic parity_bit(input logic xor_all, input logic parity_type);
    return parity_type ? xor_all : ~xor_all;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// RESET_VALUE sets what both flops hold during reset (idle-high line -> 1).
module uart_rx_sync #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_reg;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= RESET_VALUE;
      q        <= RESET_VALUE;
    end else begin
      meta_reg <= d;
      q        <= meta_reg;
    end
  end

endmodule

// File: rtl/uart_word_receiver.sv
// UART word receiver: start(0), BITS_PER_WORD data bits LSB first, parity, stop(1).
// Each bit lasts CLOCK_DIVIDER clocks and is sampled at its midpoint.
// Optional build macro UART_RX_MAJORITY_VOTE_EN: each bit becomes the 2-of-3 majority
// of the synchronized line around the midpoint, decided one cycle later.
module uart_word_receiver
  import uart_pkg::*;
#(
  parameter int BITS_PER_WORD = DEFAULT_BITS_PER_WORD,
  parameter int CLOCK_DIVIDER = DEFAULT_CLOCK_DIVIDER
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx,
  input  logic                     parity_type,
  output logic [BITS_PER_WORD-1:0] data,
  output logic                     valid,
  output logic                     parity_err,
  output logic                     frame_err,
  output logic                     busy
);

  localparam int SP    = CLOCK_DIVIDER / 2;
  localparam int CNT_W = $clog2(CLOCK_DIVIDER);
  localparam int POS_W = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int DECIDE = SP + 1;
`else
  localparam int DECIDE = SP;
`endif

  localparam logic [CNT_W-1:0] CNT_DECIDE = CNT_W'(DECIDE);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLOCK_DIVIDER - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [POS_W-1:0] POS_LAST   = POS_W'(BITS_PER_WORD - 1);
  localparam logic [POS_W-1:0] POS_ONE    = POS_W'(1);

  logic                     rx_s;
  logic                     sample_bit;
  rx_state_t                state_reg;
  rx_state_t                state_next;
  logic [CNT_W-1:0]         bit_cnt_reg;
  logic [POS_W-1:0]         bit_pos_reg;
  logic [BITS_PER_WORD-1:0] shift_reg;
  logic                     par_rx_reg;
  logic                     armed_reg;
  logic [1:0]               prime_reg;
  logic                     at_decide;
  logic                     at_end;
  logic                     start_det;
  logic                     false_start;
  logic                     frame_done;

  uart_rx_sync #(
    .RESET_VALUE(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx),
    .q  (rx_s)
  );

`ifdef UART_RX_MAJORITY_VOTE_EN
  // rx_s one and two cycles back; with the current rx_s they give the SP-1/SP/SP+1 samples.
  logic [1:0] hist_reg;

  // Short history of the synchronized line for the majority vote.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_reg <= 2'b11;
    end else begin
      hist_reg <= {hist_reg[0], rx_s};
    end
  end

  assign sample_bit = (hist_reg[1] & hist_reg[0]) | (hist_reg[1] & rx_s) | (hist_reg[0] & rx_s);
`else
  assign sample_bit = rx_s;
`endif

  // Next-state decode and the one-cycle event flags the datapath acts on.
  always_comb begin
    state_next  = state_reg;
    at_decide   = (bit_cnt_reg == CNT_DECIDE);
    at_end      = (bit_cnt_reg == CNT_LAST);
    start_det   = 1'b0;
    false_start = 1'b0;
    frame_done  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (armed_reg && !rx_s) begin
          state_next = START;
          start_det  = 1'b1;
        end
      end
      START: begin
        if (at_decide && sample_bit) begin
          state_next  = IDLE;
          false_start = 1'b1;
        end else if (at_end) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (at_end && (bit_pos_reg == POS_LAST)) begin
          state_next = PARITY;
        end
      end
      PARITY: begin
        if (at_end) begin
          state_next = STOP;
        end
      end
      STOP: begin
        // Leave at the stop-bit decision, half a bit early, so a back-to-back
        // start bit is caught on time.
        if (at_decide) begin
          state_next = IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register, bit timing, data capture and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      bit_pos_reg <= '0;
      shift_reg   <= '0;
      par_rx_reg  <= 1'b0;
      armed_reg   <= 1'b0;
      prime_reg   <= 2'b00;
      data        <= '0;
      valid       <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_reg <= state_next;
      valid     <= 1'b0;
      // The synchronizer shows its reset value for two cycles after reset; that is
      // not a real observation of the line, so it must not arm the receiver.
      prime_reg <= {prime_reg[0], 1'b1};

      if (state_reg == IDLE) begin
        bit_cnt_reg <= '0;
      end else if (at_end) begin
        bit_cnt_reg <= '0;
      end else begin
        bit_cnt_reg <= bit_cnt_reg + CNT_ONE;
      end

      case (state_reg)
        IDLE: begin
          if (rx_s && prime_reg[1]) begin
            armed_reg <= 1'b1;
          end
          if (start_det) begin
            busy <= 1'b1;
          end
        end
        START: begin
          if (false_start) begin
            busy <= 1'b0;
          end
          if (at_end) begin
            bit_pos_reg <= '0;
          end
        end
        DATA: begin
          if (at_decide) begin
            shift_reg[bit_pos_reg] <= sample_bit;
          end
          if (at_end && (bit_pos_reg != POS_LAST)) begin
            bit_pos_reg <= bit_pos_reg + POS_ONE;
          end
        end
        PARITY: begin
          if (at_decide) begin
            par_rx_reg <= sample_bit;
          end
        end
        STOP: begin
          if (frame_done) begin
            data       <= shift_reg;
            valid      <= 1'b1;
            parity_err <= (par_rx_reg != parity_bit(^shift_reg, parity_type));
            frame_err  <= ~sample_bit;
            busy       <= 1'b0;
            // A low stop bit may be the start of a break; wait for the line to
            // return high before accepting another start.
            if (!sample_bit) begin
              armed_reg <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_word_receiver.sv
// Self-checking bench for uart_word_receiver: a table of complete frames plus
// hand-written break, false-start, back-to-back, reset-abort and glitch sequences.
// Expected words go into a scoreboard queue when a frame is driven and are
// compared when the receiver strobes valid.
module tb_uart_word_receiver;

  localparam int CD  = 16;
  localparam int SP  = CD / 2;
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int EXTRA = 1;
  localparam bit MAJ   = 1'b1;
`else
  localparam int EXTRA = 0;
  localparam bit MAJ   = 1'b0;
`endif
  // Cycles from the first clock edge that sees the low start bit to the edge that raises valid.
  localparam int LAT = 2 + 34 * CD + SP + 1 + EXTRA;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic        parity_type = 1'b1;
  logic [31:0] data;
  logic        valid;
  logic        parity_err;
  logic        frame_err;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int valid_count = 0;
  int last_valid_cyc = 0;
  int frame_start_cyc = 0;
  int cyc = 0;
  int stray = 0;

  typedef struct {
    logic [31:0] d;
    logic        pe;
    logic        fe;
  } exp_t;

  typedef struct {
    logic [31:0] d;
    logic        ptype;
    logic        bad_par;
    logic        stop_val;
    logic        exp_pe;
    logic        exp_fe;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[5];

  uart_word_receiver #(
    .BITS_PER_WORD(32),
    .CLOCK_DIVIDER(CD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .parity_type(parity_type),
    .data       (data),
    .valid      (valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic [31:0] d, input logic pe, input logic fe);
    exp_t e;
    e.d  = d;
    e.pe = pe;
    e.fe = fe;
    sb_q.push_back(e);
  endtask

  // Scoreboard: every valid strobe pops one expected word.
  always @(negedge clk) begin
    exp_t e;
    if (valid === 1'b1) begin
      valid_count++;
      last_valid_cyc = cyc;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got valid with data %h, required no valid", data);
      end else begin
        e = sb_q.pop_front();
        chk("data", data, e.d);
        chk("parity_err", {31'd0, parity_err}, {31'd0, e.pe});
        chk("frame_err", {31'd0, frame_err}, {31'd0, e.fe});
        $display("rx word %h parity_err=%0b frame_err=%0b at cycle %0d", data, parity_err, frame_err, cyc);
      end
    end
  end

  // Serial frame driver (stands in for the transmitter). glitch_bit/rst_bit < 0 disable
  // the one-cycle line glitch and the mid-frame reset respectively.
  task automatic send_frame(input logic [31:0] d, input logic ptype, input logic bad_par,
                            input logic stop_val, input int glitch_bit, input int rst_bit);
    logic [34:0] frame;
    logic        par;
    par         = ptype ? ^d : ~^d;
    frame       = {stop_val, par ^ bad_par, d, 1'b0};
    parity_type = ptype;
    frame_start_cyc = cyc;
    for (int k = 0; k < 35; k++) begin
      for (int c = 0; c < CD; c++) begin
        rx = frame[k];
        if (glitch_bit >= 0 && k == glitch_bit + 1 && c == SP + 1) rx = ~frame[k];
        rst = (rst_bit >= 0 && k == rst_bit + 1 && c == SP);
        if (rst_bit >= 0 && k == rst_bit + 1 && c == SP + 1) begin
          chk("rst_data", data, 32'h0);
          chk("rst_valid", {31'd0, valid}, 32'd0);
          chk("rst_parity_err", {31'd0, parity_err}, 32'd0);
          chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
          chk("rst_busy", {31'd0, busy}, 32'd0);
        end
        if (rst_bit >= 0 && (k > rst_bit + 1 || (k == rst_bit + 1 && c > SP + 1)) &&
            (busy === 1'b1 || valid === 1'b1)) stray++;
        @(negedge clk);
      end
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int target, input string name);
    int n = 0;
    while (valid_count < target && n < 40 * CD) begin
      @(negedge clk);
      n++;
    end
    chk(name, valid_count, target);
  endtask

  initial begin
    int target;
    int hold_bad;
    bit saw_busy;

    vecs[0] = '{32'hA5A5_0F0F, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{32'h1234_5678, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{32'h8001_7FFE, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    // Reset state
    rst = 1'b1;
    rx  = 1'b1;
    repeat (4) @(negedge clk);
    chk("reset_data", data, 32'h0);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_parity_err", {31'd0, parity_err}, 32'd0);
    chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    idle(3 * CD);

    // Table of complete frames, each followed by an idle gap
    for (int i = 0; i < 5; i++) begin
      target = valid_count + 1;
      expect_word(vecs[i].d, vecs[i].exp_pe, vecs[i].exp_fe);
      send_frame(vecs[i].d, vecs[i].ptype, vecs[i].bad_par, vecs[i].stop_val, -1, -1);
      wait_valid(target, "table_valid_count");
      chk("latency", last_valid_cyc - frame_start_cyc, LAT + 1);
      chk("busy_after_frame", {31'd0, busy}, 32'd0);
      idle(2 * CD);
    end

    // Stop bit low, then a 100-bit break: one frame-error word, then silence
    target = valid_count + 1;
    expect_word(32'hFFFF_FFFF, 1'b0, 1'b1);
    send_frame(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, -1, -1);
    wait_valid(target, "break_valid_count");
    hold_bad = 0;
    rx = 1'b0;
    for (int c = 0; c < 100 * CD; c++) begin
      @(negedge clk);
      if (busy === 1'b1 || valid === 1'b1) hold_bad++;
    end
    chk("break_quiet", hold_bad, 0);
    idle(2 * CD);
    target = valid_count + 1;
    expect_word(32'h0BAD_CAFE, 1'b0, 1'b0);
    send_frame(32'h0BAD_CAFE, 1'b1, 1'b0, 1'b1, -1, -1);
    wait_valid(target, "after_break_valid_count");
    idle(2 * CD);

    // Short low pulse: false start
    target   = valid_count;
    saw_busy = 1'b0;
    rx = 1'b0;
    repeat (CD / 4) begin
      @(negedge clk);
      if (busy === 1'b1) saw_busy = 1'b1;
    end
    rx = 1'b1;
    repeat (3 * CD) begin
      @(negedge clk);
      if (busy === 1'b1) saw_busy = 1'b1;
    end
    chk("false_start_busy_seen", {31'd0, saw_busy}, 32'd1);
    chk("false_start_busy_end", {31'd0, busy}, 32'd0);
    chk("false_start_no_valid", valid_count, target);

    // Back-to-back frames with no idle gap
    target = valid_count + 2;
    expect_word(32'h0000_0001, 1'b0, 1'b0);
    expect_word(32'h8000_0000, 1'b0, 1'b0);
    send_frame(32'h0000_0001, 1'b1, 1'b0, 1'b1, -1, -1);
    send_frame(32'h8000_0000, 1'b1, 1'b0, 1'b1, -1, -1);
    wait_valid(target, "back_to_back_valid_count");
    idle(2 * CD);

    // Reset at data bit 10; the rest of that frame must be ignored
    stray  = 0;
    target = valid_count;
    send_frame(32'h0000_0155, 1'b1, 1'b0, 1'b1, -1, 10);
    idle(4 * CD);
    chk("abort_stray_activity", stray, 0);
    chk("abort_no_valid", valid_count, target);
    target = valid_count + 1;
    expect_word(32'h1357_9BDF, 1'b0, 1'b0);
    send_frame(32'h1357_9BDF, 1'b1, 1'b0, 1'b1, -1, -1);
    wait_valid(target, "after_abort_valid_count");
    idle(2 * CD);

    // One-cycle glitch at the sample point of data bit 3
    target = valid_count + 1;
    if (MAJ) expect_word(32'hCAFE_0000, 1'b0, 1'b0);
    else     expect_word(32'hCAFE_0008, 1'b1, 1'b0);
    send_frame(32'hCAFE_0000, 1'b1, 1'b0, 1'b1, 3, -1);
    wait_valid(target, "glitch_valid_count");
    idle(2 * CD);

    chk("scoreboard_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
